// File: rtl/wisc_perf_pkg.sv
// Shared constants for the WISC performance monitor: FSM encodings, readout indices and default sizes.
package wisc_perf_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_RUN    = 2'd1;
   localparam logic [1:0] ST_FROZEN = 2'd2;

   localparam int SEL_CYCLES  = 0;
   localparam int SEL_INSTS   = 1;
   localparam int SEL_EV_BASE = 2;

   localparam int DEF_NUM_EVENTS = 8;
   localparam int DEF_CNT_WIDTH  = 32;
   localparam int DEF_SEL_WIDTH  = 6;
   localparam int DEF_WDOG_LIMIT = 100000;

   function automatic int num_counters(input int num_events);
      return num_events + SEL_EV_BASE;
   endfunction

endpackage

// File: rtl/wisc_sat_counter.sv
// Saturating up-counter with a sticky flag that marks the counter having reached all-ones.
module wisc_sat_counter
   import wisc_perf_pkg::*;
#(
   parameter int CNT_WIDTH = DEF_CNT_WIDTH
)
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 inc,
   output logic [CNT_WIDTH-1:0] value,
   output logic                 ovf
);

   localparam logic [CNT_WIDTH-1:0] MAX_VAL = '1;

   // The flag follows the value: it rises on the same edge the value lands on all-ones.
   always_ff @(posedge clk) begin
      if (!rst || clr) begin
         value <= '0;
         ovf   <= 1'b0;
      end else if (inc) begin
         if (value != MAX_VAL) begin
            value <= value + CNT_WIDTH'(1);
         end
         if (value >= MAX_VAL - CNT_WIDTH'(1)) begin
            ovf <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/wisc_perf_monitor.sv
// WISC performance monitor: cycle, retired-instruction and generic event counters with run/freeze
// control and a registered readout port. Optional watchdog built when WISC_PERF_WATCHDOG_EN is defined.
module wisc_perf_monitor
   import wisc_perf_pkg::*;
#(
   parameter int NUM_EVENTS = DEF_NUM_EVENTS,
   parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
   parameter int SEL_WIDTH  = DEF_SEL_WIDTH,
   parameter int WDOG_LIMIT = DEF_WDOG_LIMIT
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  clr,
   input  logic                  retire_reg_write,
   input  logic                  retire_mem_write,
   input  logic                  retire_halt,
   input  logic [NUM_EVENTS-1:0] ev,
   input  logic                  rd_req,
   input  logic [SEL_WIDTH-1:0]  rd_sel,
   output logic                  rd_valid,
   output logic [CNT_WIDTH-1:0]  rd_data,
   output logic                  rd_err,
   output logic [1:0]            state_o,
   output logic                  ovf_any,
   output logic                  wdog_timeout
);

   localparam int NUM_CNT = num_counters(NUM_EVENTS);

   logic [1:0]           state;
   logic                 run;
   logic                 wdog_fire;
   logic [NUM_CNT-1:0]   cnt_inc;
   logic [NUM_CNT-1:0]   cnt_ovf;
   logic [CNT_WIDTH-1:0] cnt_val [NUM_CNT];
   logic [CNT_WIDTH-1:0] sel_val;
   logic                 sel_ok;

   assign run     = (state == ST_RUN);
   assign state_o = state;

   // clr outranks everything; halt (or a watchdog trip) outranks dropping en while running.
   always_ff @(posedge clk) begin
      if (!rst || clr) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:   if (en) state <= ST_RUN;
            ST_RUN:    begin
               if (retire_halt || wdog_fire) begin
                  state <= ST_FROZEN;
               end else if (!en) begin
                  state <= ST_IDLE;
               end
            end
            ST_FROZEN: state <= ST_FROZEN;
            default:   state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      cnt_inc             = '0;
      cnt_inc[SEL_CYCLES] = run;
      cnt_inc[SEL_INSTS]  = run & (retire_reg_write | retire_mem_write | retire_halt);
      for (int i = 0; i < NUM_EVENTS; i++) begin
         cnt_inc[SEL_EV_BASE + i] = run & ev[i];
      end
   end

   for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
      wisc_sat_counter #(
         .CNT_WIDTH (CNT_WIDTH)
      ) u_cnt (
         .clk   (clk),
         .rst   (rst),
         .clr   (clr),
         .inc   (cnt_inc[g]),
         .value (cnt_val[g]),
         .ovf   (cnt_ovf[g])
      );
   end

   always_ff @(posedge clk) begin
      if (!rst || clr) begin
         ovf_any <= 1'b0;
      end else begin
         ovf_any <= |cnt_ovf;
      end
   end

   // Out-of-range selects match nothing, leaving sel_val at zero and sel_ok low.
   always_comb begin
      sel_val = '0;
      sel_ok  = 1'b0;
      for (int i = 0; i < NUM_CNT; i++) begin
         if (rd_sel == SEL_WIDTH'(i)) begin
            sel_val = cnt_val[i];
            sel_ok  = 1'b1;
         end
      end
   end

   // Readout captures pre-edge values and ignores clr, so a read alongside clr sees the old count.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
         rd_err   <= 1'b0;
      end else begin
         rd_valid <= rd_req;
         rd_data  <= rd_req ? sel_val : '0;
         rd_err   <= rd_req & ~sel_ok;
      end
   end

`ifdef WISC_PERF_WATCHDOG_EN
   localparam logic [63:0]          WDOG_LIM64 = 64'(WDOG_LIMIT);
   localparam logic [CNT_WIDTH-1:0] WDOG_MAX   = '1;

   logic [CNT_WIDTH-1:0] wdog_cnt;

   assign wdog_fire = run && (64'(wdog_cnt) > WDOG_LIM64);

   always_ff @(posedge clk) begin
      if (!rst || clr) begin
         wdog_cnt     <= '0;
         wdog_timeout <= 1'b0;
      end else begin
         if (run && (wdog_cnt != WDOG_MAX)) begin
            wdog_cnt <= wdog_cnt + CNT_WIDTH'(1);
         end
         if (wdog_fire) begin
            wdog_timeout <= 1'b1;
         end
      end
   end
`else
   // Without the watchdog the limit has no effect; this folds to a constant low.
   assign wdog_fire    = 1'b0;
   assign wdog_timeout = (WDOG_LIMIT < 0) ? 1'b1 : 1'b0;
`endif

endmodule

// File: tb/tb_wisc_perf_monitor.sv
// Bench for wisc_perf_monitor: directed vector table, saturation/watchdog sequences, random run vs reference model.
module tb_wisc_perf_monitor;

   localparam int NE   = 8;
   localparam int CW   = 8;
   localparam int SW   = 6;
   localparam int WDL  = 20;
   localparam int NCNT = NE + 2;
   localparam int MAXV = (1 << CW) - 1;
   localparam int M_IDLE   = 0;
   localparam int M_RUN    = 1;
   localparam int M_FROZEN = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          clr;
   logic          retire_reg_write;
   logic          retire_mem_write;
   logic          retire_halt;
   logic [NE-1:0] ev;
   logic          rd_req;
   logic [SW-1:0] rd_sel;
   logic          rd_valid;
   logic [CW-1:0] rd_data;
   logic          rd_err;
   logic [1:0]    state_o;
   logic          ovf_any;
   logic          wdog_timeout;

   always #5 clk = ~clk;

   wisc_perf_monitor #(
      .NUM_EVENTS (NE),
      .CNT_WIDTH  (CW),
      .SEL_WIDTH  (SW),
      .WDOG_LIMIT (WDL)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .en               (en),
      .clr              (clr),
      .retire_reg_write (retire_reg_write),
      .retire_mem_write (retire_mem_write),
      .retire_halt      (retire_halt),
      .ev               (ev),
      .rd_req           (rd_req),
      .rd_sel           (rd_sel),
      .rd_valid         (rd_valid),
      .rd_data          (rd_data),
      .rd_err           (rd_err),
      .state_o          (state_o),
      .ovf_any          (ovf_any),
      .wdog_timeout     (wdog_timeout)
   );

   typedef struct {
      logic          rst;
      logic          en;
      logic          clr;
      logic          rw;
      logic          mw;
      logic          halt;
      logic [NE-1:0] ev;
      logic          rd_req;
      logic [SW-1:0] rd_sel;
   } stim_t;

   typedef struct {
      stim_t in;
      int    exp_state;
      logic  exp_valid;
      int    exp_data;
      logic  exp_err;
   } vec_t;

   int m_cnt [NCNT];
   int m_state;
   bit m_ovf;
   bit m_wto;
`ifdef WISC_PERF_WATCHDOG_EN
   int m_wd;
`endif
   bit e_valid;
   bit e_err;
   int e_data;

   int n_checks = 0;
   int n_fail   = 0;

   function automatic int sat_inc(input int v);
      return (v >= MAXV) ? MAXV : v + 1;
   endfunction

   function automatic stim_t mk(input bit r, input bit e, input bit c, input bit w, input bit m,
                                input bit h, input logic [NE-1:0] evv, input bit q, input int sel);
      stim_t s;
      s.rst    = r;
      s.en     = e;
      s.clr    = c;
      s.rw     = w;
      s.mw     = m;
      s.halt   = h;
      s.ev     = evv;
      s.rd_req = q;
      s.rd_sel = SW'(sel);
      return s;
   endfunction

   function automatic vec_t mkv(input stim_t s, input int st, input bit v, input int d, input bit er);
      vec_t t;
      t.in        = s;
      t.exp_state = st;
      t.exp_valid = v;
      t.exp_data  = d;
      t.exp_err   = er;
      return t;
   endfunction

   task automatic checkOutput(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs, advance the reference model by the documented rules, then step the clock.
   task automatic applyStimulus(input stim_t s);
      bit any_sat;
      bit fire;
      rst              = s.rst;
      en               = s.en;
      clr              = s.clr;
      retire_reg_write = s.rw;
      retire_mem_write = s.mw;
      retire_halt      = s.halt;
      ev               = s.ev;
      rd_req           = s.rd_req;
      rd_sel           = s.rd_sel;
      if (!s.rst) begin
         foreach (m_cnt[i]) m_cnt[i] = 0;
         m_state = M_IDLE;
         m_ovf   = 1'b0;
         m_wto   = 1'b0;
`ifdef WISC_PERF_WATCHDOG_EN
         m_wd    = 0;
`endif
         e_valid = 1'b0;
         e_err   = 1'b0;
         e_data  = 0;
      end else begin
         e_valid = s.rd_req;
         e_err   = s.rd_req && (int'(s.rd_sel) >= NCNT);
         e_data  = (s.rd_req && int'(s.rd_sel) < NCNT) ? m_cnt[int'(s.rd_sel)] : 0;
         any_sat = 1'b0;
         foreach (m_cnt[i]) if (m_cnt[i] == MAXV) any_sat = 1'b1;
         if (s.clr) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_state = M_IDLE;
            m_ovf   = 1'b0;
            m_wto   = 1'b0;
`ifdef WISC_PERF_WATCHDOG_EN
            m_wd    = 0;
`endif
         end else begin
            fire = 1'b0;
`ifdef WISC_PERF_WATCHDOG_EN
            fire = (m_state == M_RUN) && (m_wd > WDL);
            if (m_state == M_RUN) m_wd = sat_inc(m_wd);
            if (fire) m_wto = 1'b1;
`endif
            if (m_state == M_RUN) begin
               m_cnt[0] = sat_inc(m_cnt[0]);
               if (s.rw || s.mw || s.halt) m_cnt[1] = sat_inc(m_cnt[1]);
               for (int i = 0; i < NE; i++) begin
                  if (s.ev[i]) m_cnt[2 + i] = sat_inc(m_cnt[2 + i]);
               end
               if (s.halt || fire) m_state = M_FROZEN;
               else if (!s.en) m_state = M_IDLE;
            end else if (m_state == M_IDLE && s.en) begin
               m_state = M_RUN;
            end
            m_ovf = any_sat;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic checkModel(input string tag);
      checkOutput({tag, " state_o"},      longint'(state_o),      longint'(m_state));
      checkOutput({tag, " rd_valid"},     longint'(rd_valid),     longint'(e_valid));
      checkOutput({tag, " rd_err"},       longint'(rd_err),       longint'(e_err));
      checkOutput({tag, " rd_data"},      longint'(rd_data),      longint'(e_data));
      checkOutput({tag, " ovf_any"},      longint'(ovf_any),      longint'(m_ovf));
      checkOutput({tag, " wdog_timeout"}, longint'(wdog_timeout), longint'(m_wto));
   endtask

   vec_t  tbl [18];
   stim_t idle;
   stim_t r;

   initial begin
      idle = mk(1, 0, 0, 0, 0, 0, '0, 0, 0);

      tbl[0]  = mkv(mk(0, 0, 0, 0, 0, 0, 8'h00, 0, 0),  0, 0, 0, 0);
      tbl[1]  = mkv(mk(0, 0, 0, 0, 0, 0, 8'h00, 0, 0),  0, 0, 0, 0);
      tbl[2]  = mkv(mk(1, 1, 0, 0, 0, 0, 8'h00, 0, 0),  1, 0, 0, 0);
      tbl[3]  = mkv(mk(1, 1, 0, 0, 0, 0, 8'h00, 1, 0),  1, 1, 0, 0);
      tbl[4]  = mkv(mk(1, 1, 0, 1, 0, 0, 8'h00, 0, 0),  1, 0, 0, 0);
      tbl[5]  = mkv(mk(1, 1, 0, 1, 0, 0, 8'h00, 1, 0),  1, 1, 2, 0);
      tbl[6]  = mkv(mk(1, 1, 0, 0, 1, 0, 8'h05, 1, 1),  1, 1, 2, 0);
      tbl[7]  = mkv(mk(1, 0, 0, 0, 0, 0, 8'h00, 1, 2),  0, 1, 1, 0);
      tbl[8]  = mkv(mk(1, 0, 0, 1, 0, 0, 8'hFF, 1, 4),  0, 1, 1, 0);
      tbl[9]  = mkv(mk(1, 0, 0, 0, 0, 0, 8'h00, 1, 0),  0, 1, 5, 0);
      tbl[10] = mkv(mk(1, 1, 0, 0, 0, 0, 8'h00, 1, 10), 1, 1, 0, 1);
      tbl[11] = mkv(mk(1, 1, 0, 0, 0, 1, 8'h00, 1, 1),  2, 1, 3, 0);
      tbl[12] = mkv(mk(1, 1, 0, 1, 0, 0, 8'hFF, 1, 0),  2, 1, 6, 0);
      tbl[13] = mkv(mk(1, 0, 0, 0, 0, 0, 8'h00, 1, 2),  2, 1, 1, 0);
      tbl[14] = mkv(mk(1, 0, 1, 0, 0, 1, 8'hFF, 1, 1),  0, 1, 4, 0);
      tbl[15] = mkv(mk(1, 0, 0, 0, 0, 0, 8'h00, 1, 1),  0, 1, 0, 0);
      tbl[16] = mkv(mk(1, 0, 0, 0, 0, 0, 8'h00, 1, 0),  0, 1, 0, 0);
      tbl[17] = mkv(mk(1, 0, 0, 0, 0, 0, 8'h00, 0, 0),  0, 0, 0, 0);

      $display("[TB] directed vector table");
      for (int i = 0; i < 18; i++) begin
         applyStimulus(tbl[i].in);
         checkModel($sformatf("vec%0d", i));
         checkOutput($sformatf("vec%0d tbl state", i), longint'(state_o),  longint'(tbl[i].exp_state));
         checkOutput($sformatf("vec%0d tbl valid", i), longint'(rd_valid), longint'(tbl[i].exp_valid));
         checkOutput($sformatf("vec%0d tbl data", i),  longint'(rd_data),  longint'(tbl[i].exp_data));
         checkOutput($sformatf("vec%0d tbl err", i),   longint'(rd_err),   longint'(tbl[i].exp_err));
      end

      $display("[TB] saturation sequence");
      applyStimulus(mk(1, 0, 1, 0, 0, 0, '0, 0, 0));
      checkModel("sat clr");
      for (int i = 0; i < 300; i++) begin
         applyStimulus(mk(1, 1, 0, 0, 0, 0, 8'h01, 0, 0));
         checkModel("sat run");
      end
      applyStimulus(mk(1, 0, 0, 0, 0, 0, '0, 1, 2));
      checkModel("sat rd ev0");
`ifndef WISC_PERF_WATCHDOG_EN
      checkOutput("sat ev0 value", longint'(rd_data), 255);
      checkOutput("sat ovf_any",   longint'(ovf_any), 1);
`endif
      applyStimulus(mk(1, 0, 0, 0, 0, 0, '0, 1, 0));
      checkModel("sat rd cycles");
`ifndef WISC_PERF_WATCHDOG_EN
      checkOutput("sat cycles value", longint'(rd_data), 255);
`endif

      $display("[TB] watchdog sequence");
      applyStimulus(mk(1, 0, 1, 0, 0, 0, '0, 0, 0));
      checkModel("wd clr");
      for (int i = 0; i < 30; i++) begin
         applyStimulus(mk(1, 1, 0, 0, 0, 0, '0, 0, 0));
         checkModel("wd run");
      end
`ifdef WISC_PERF_WATCHDOG_EN
      checkOutput("wd timeout set", longint'(wdog_timeout), 1);
      checkOutput("wd frozen",      longint'(state_o),      2);
`else
      checkOutput("wd timeout low", longint'(wdog_timeout), 0);
      checkOutput("wd still run",   longint'(state_o),      1);
`endif
      applyStimulus(idle);
      checkModel("wd idle");

      $display("[TB] randomized run");
      for (int i = 0; i < 2000; i++) begin
         r.rst    = ($urandom_range(0, 63) != 0);
         r.en     = ($urandom_range(0, 3) != 0);
         r.clr    = ($urandom_range(0, 31) == 0);
         r.rw     = 1'($urandom);
         r.mw     = ($urandom_range(0, 3) == 0);
         r.halt   = ($urandom_range(0, 15) == 0);
         r.ev     = NE'($urandom);
         r.rd_req = ($urandom_range(0, 3) != 0);
         r.rd_sel = SW'($urandom_range(0, 15));
         applyStimulus(r);
         checkModel($sformatf("rand%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
